// File: rtl/amem_pkg.sv
// amem_pkg
// Shared definitions for the APP analog memory core controller:
// default geometry constants, the capture FSM state type and the
// cell one-hot decode used to drive the analog sample selects.
// No ports (package).
package amem_pkg;

  localparam int NCELLS_DEF = 8;
  localparam int CNT_W_DEF  = 8;
  localparam int META_W_DEF = 8;

  // Widest cell bank supported; decode is done at this width and
  // narrowed by the caller to its own NCELLS.
  localparam int MAX_CELLS = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SAMPLE = 1'b1
  } state_t;

  function automatic logic [MAX_CELLS-1:0] cell_onehot(input logic [3:0] idx);
    cell_onehot      = '0;
    cell_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/amem_cell_bank.sv
// amem_cell_bank
// Per-cell storage of event metadata and TOT width for the analog
// memory controller. A whole event is written at once when it commits.
// Ports:
//   clk, resetb      clock and synchronous active-low reset (clears storage)
//   i_wr_en          write strobe
//   i_wr_idx         cell written
//   i_wr_meta/tot    event metadata and TOT width to store
//   i_rd_idx         cell read (asynchronous read port)
//   o_rd_meta/tot    stored metadata and TOT width of i_rd_idx
module amem_cell_bank
  import amem_pkg::*;
#(
  parameter int NCELLS = NCELLS_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int META_W = META_W_DEF,
  localparam int IDX_W = $clog2(NCELLS)
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [META_W-1:0] i_wr_meta,
  input  logic [CNT_W-1:0]  i_wr_tot,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [META_W-1:0] o_rd_meta,
  output logic [CNT_W-1:0]  o_rd_tot
);

  logic [META_W-1:0] r_meta [NCELLS];
  logic [CNT_W-1:0]  r_tot  [NCELLS];

  // Storage is cleared on reset so a read of a never-written cell is
  // deterministic.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      for (int i = 0; i < NCELLS; i++) begin
        r_meta[i] <= '0;
        r_tot[i]  <= '0;
      end
    end else if (i_wr_en) begin
      r_meta[i_wr_idx] <= i_wr_meta;
      r_tot[i_wr_idx]  <= i_wr_tot;
    end
  end

  assign o_rd_meta = r_meta[i_rd_idx];
  assign o_rd_tot  = r_tot[i_rd_idx];

endmodule

// File: rtl/amem_core_ctl.sv
// amem_core_ctl
// Controller for the APP analog memory core. Detects TOT pulses,
// allocates a storage cell per pulse, drives its one-hot sample
// select, measures the pulse width and serves events to readout FIFO-order.
// Ports:
//   clk, resetb_full  clock and synchronous active-low reset
//   TOT               comparator time-over-threshold level (synchronous)
//   metadata          event tag, sampled on the TOT rise
//   rd_req            readout request
//   rd_valid          one-cycle strobe qualifying rd_meta/rd_tot/rd_cell
//   wr_sel            one-hot analog sample select, zero when idle
//   occupancy         committed unread events; full/empty derived from it
//   overflow          sticky: a pulse was dropped because all cells were busy
module amem_core_ctl
  import amem_pkg::*;
#(
  parameter int NCELLS = NCELLS_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int META_W = META_W_DEF,
  localparam int IDX_W = $clog2(NCELLS),
  localparam int OCC_W = IDX_W + 1
) (
  input  logic              clk,
  input  logic              resetb_full,
  input  logic              TOT,
  input  logic [META_W-1:0] metadata,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [META_W-1:0] rd_meta,
  output logic [CNT_W-1:0]  rd_tot,
  output logic [IDX_W-1:0]  rd_cell,
  output logic [NCELLS-1:0] wr_sel,
  output logic [OCC_W-1:0]  occupancy,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  state_t            r_state, w_next_state;
  logic              r_tot_q;
  logic [CNT_W-1:0]  r_cnt;
  logic [META_W-1:0] r_meta_hold;
  logic [IDX_W-1:0]  r_wptr, r_rptr;
  logic [OCC_W-1:0]  r_occ;
  logic              r_overflow;
  logic              r_rd_valid;
  logic [META_W-1:0] r_rd_meta;
  logic [CNT_W-1:0]  r_rd_tot;
  logic [IDX_W-1:0]  r_rd_cell;

  logic              w_rise, w_fall;
  logic              w_start, w_commit, w_drop, w_rd_grant;
  logic              w_full, w_empty;
  logic [META_W-1:0] w_bank_meta;
  logic [CNT_W-1:0]  w_bank_tot;

  assign w_rise  = TOT & ~r_tot_q;
  assign w_fall  = ~TOT & r_tot_q;
  assign w_full  = (r_occ == OCC_W'(NCELLS));
  assign w_empty = (r_occ == '0);

  // A read is granted only when something is committed and the previous
  // strobe has finished, so each grant yields exactly one rd_valid cycle.
  assign w_rd_grant = rd_req & ~w_empty & ~r_rd_valid;

  always_ff @(posedge clk) begin
    if (!resetb_full) r_state <= ST_IDLE;
    else              r_state <= w_next_state;
  end

  // The full check at the rise is what keeps an unread cell from being
  // reallocated: occupancy counts committed cells only, and the cell at
  // wptr is free whenever occupancy is below NCELLS.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_commit     = 1'b0;
    w_drop       = 1'b0;
    wr_sel       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          if (w_full) begin
            w_drop = 1'b1;
          end else begin
            w_start      = 1'b1;
            w_next_state = ST_SAMPLE;
          end
        end
      end
      ST_SAMPLE: begin
        wr_sel = NCELLS'(cell_onehot(4'(r_wptr)));
        if (w_fall) begin
          w_commit     = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Metadata is held until the commit so the cell bank sees the whole
  // event in a single write; only committed cells are ever read.
  always_ff @(posedge clk) begin
    if (!resetb_full) begin
      r_tot_q     <= 1'b0;
      r_cnt       <= '0;
      r_meta_hold <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_occ       <= '0;
      r_overflow  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_meta   <= '0;
      r_rd_tot    <= '0;
      r_rd_cell   <= '0;
    end else begin
      r_tot_q <= TOT;

      if (w_start) begin
        r_meta_hold <= metadata;
        r_cnt       <= CNT_W'(1);
      end else if (r_state == ST_SAMPLE && TOT && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_drop)   r_overflow <= 1'b1;
      if (w_commit) r_wptr     <= r_wptr + 1'b1;

      r_rd_valid <= w_rd_grant;
      if (w_rd_grant) begin
        r_rd_meta <= w_bank_meta;
        r_rd_tot  <= w_bank_tot;
        r_rd_cell <= r_rptr;
        r_rptr    <= r_rptr + 1'b1;
      end

      case ({w_commit, w_rd_grant})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  amem_cell_bank #(
    .NCELLS(NCELLS),
    .CNT_W (CNT_W),
    .META_W(META_W)
  ) u_bank (
    .clk      (clk),
    .resetb   (resetb_full),
    .i_wr_en  (w_commit),
    .i_wr_idx (r_wptr),
    .i_wr_meta(r_meta_hold),
    .i_wr_tot (r_cnt),
    .i_rd_idx (r_rptr),
    .o_rd_meta(w_bank_meta),
    .o_rd_tot (w_bank_tot)
  );

  assign rd_valid  = r_rd_valid;
  assign rd_meta   = r_rd_meta;
  assign rd_tot    = r_rd_tot;
  assign rd_cell   = r_rd_cell;
  assign occupancy = r_occ;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_amem_core_ctl.sv
// tb_amem_core_ctl
// Directed self-checking bench for amem_core_ctl with default geometry
// (8 cells, 8-bit counter, 8-bit metadata). Inputs change and outputs
// are sampled 1 ns after each rising clock edge.
module tb_amem_core_ctl;

  logic       clk = 1'b0;
  logic       resetb_full;
  logic       TOT;
  logic [7:0] metadata;
  logic       rd_req;
  logic       rd_valid;
  logic [7:0] rd_meta;
  logic [7:0] rd_tot;
  logic [2:0] rd_cell;
  logic [7:0] wr_sel;
  logic [3:0] occupancy;
  logic       full;
  logic       empty;
  logic       overflow;

  int nChecks = 0;
  int nBad    = 0;

  amem_core_ctl dut (
    .clk        (clk),
    .resetb_full(resetb_full),
    .TOT        (TOT),
    .metadata   (metadata),
    .rd_req     (rd_req),
    .rd_valid   (rd_valid),
    .rd_meta    (rd_meta),
    .rd_tot     (rd_tot),
    .rd_cell    (rd_cell),
    .wr_sel     (wr_sel),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One TOT pulse sampled high on `width` edges, then the commit edge.
  task automatic applyStimulus(input int width, input logic [7:0] meta);
    metadata = meta;
    TOT      = 1'b1;
    repeat (width) tick();
    TOT = 1'b0;
    tick();
  endtask

  // Request one event and check the strobe and its data.
  task automatic readEvent(input string tag, input logic [7:0] eMeta,
                           input logic [7:0] eTot, input logic [2:0] eCell);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checkOutput({tag, ".valid"}, 32'(rd_valid), 32'd1);
    checkOutput({tag, ".meta"},  32'(rd_meta),  32'(eMeta));
    checkOutput({tag, ".tot"},   32'(rd_tot),   32'(eTot));
    checkOutput({tag, ".cell"},  32'(rd_cell),  32'(eCell));
    tick();
    checkOutput({tag, ".validDrop"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    resetb_full = 1'b0;
    TOT         = 1'b0;
    metadata    = 8'h00;
    rd_req      = 1'b0;
    tick();
    tick();
    resetb_full = 1'b1;

    // Reset state
    checkOutput("rst.wr_sel",   32'(wr_sel),    32'h00);
    checkOutput("rst.rd_valid", 32'(rd_valid),  32'd0);
    checkOutput("rst.occ",      32'(occupancy), 32'd0);
    checkOutput("rst.empty",    32'(empty),     32'd1);
    checkOutput("rst.full",     32'(full),      32'd0);
    checkOutput("rst.overflow", 32'(overflow),  32'd0);
    checkOutput("rst.rd_meta",  32'(rd_meta),   32'd0);

    // Single event: tag A5, 5 cycles high, cell 0
    metadata = 8'hA5;
    TOT      = 1'b1;
    tick();
    checkOutput("single.wr_sel_rise", 32'(wr_sel), 32'h01);
    repeat (3) tick();
    checkOutput("single.wr_sel_mid", 32'(wr_sel), 32'h01);
    checkOutput("single.occ_mid",    32'(occupancy), 32'd0);
    tick();
    TOT = 1'b0;
    tick();
    checkOutput("single.wr_sel_fall", 32'(wr_sel),    32'h00);
    checkOutput("single.occ",         32'(occupancy), 32'd1);
    checkOutput("single.empty",       32'(empty),     32'd0);
    readEvent("single.rd", 8'hA5, 8'd5, 3'd0);
    checkOutput("single.empty_after", 32'(empty),   32'd1);
    checkOutput("single.meta_hold",   32'(rd_meta), 32'hA5);

    // Empty read: no strobe, read pointer stays at 1
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checkOutput("emptyrd.valid", 32'(rd_valid), 32'd0);
    tick();
    checkOutput("emptyrd.valid2", 32'(rd_valid), 32'd0);
    checkOutput("emptyrd.occ",    32'(occupancy), 32'd0);

    // Fill: 8 pulses widths 1..8, tags 0..7, cells 1..7,0
    for (int i = 0; i < 8; i++) applyStimulus(i + 1, 8'(i));
    checkOutput("fill.full",  32'(full),      32'd1);
    checkOutput("fill.occ",   32'(occupancy), 32'd8);
    checkOutput("fill.ovf0",  32'(overflow),  32'd0);

    // Ninth pulse is dropped
    metadata = 8'hEE;
    TOT      = 1'b1;
    tick();
    checkOutput("ovf.wr_sel", 32'(wr_sel),   32'h00);
    checkOutput("ovf.flag",   32'(overflow), 32'd1);
    repeat (2) tick();
    checkOutput("ovf.wr_sel_mid", 32'(wr_sel), 32'h00);
    TOT = 1'b0;
    tick();
    checkOutput("ovf.occ", 32'(occupancy), 32'd8);

    for (int i = 0; i < 8; i++)
      readEvent($sformatf("fill.rd%0d", i), 8'(i), 8'(i + 1), 3'((i + 1) % 8));
    checkOutput("fill.empty",     32'(empty),    32'd1);
    checkOutput("fill.ovfSticky", 32'(overflow), 32'd1);

    // Saturation: 300 high cycles, cell 1
    applyStimulus(300, 8'h3C);
    readEvent("sat.rd", 8'h3C, 8'd255, 3'd1);

    // Advance both pointers to 7 (cells 2..6)
    for (int i = 0; i < 5; i++) applyStimulus(2, 8'(8'h10 + i));
    for (int i = 0; i < 5; i++)
      readEvent($sformatf("adv.rd%0d", i), 8'(8'h10 + i), 8'd2, 3'(i + 2));

    // Back-to-back: event A in cell 7, one low cycle, event B in cell 0
    metadata = 8'h71;
    TOT      = 1'b1;
    tick();
    checkOutput("b2b.wr_selA", 32'(wr_sel), 32'h80);
    repeat (2) tick();
    TOT = 1'b0;
    tick();
    checkOutput("b2b.occA", 32'(occupancy), 32'd1);
    metadata = 8'h72;
    TOT      = 1'b1;
    tick();
    checkOutput("b2b.wr_selB", 32'(wr_sel), 32'h01);
    tick();
    TOT    = 1'b0;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checkOutput("b2b.occSteady", 32'(occupancy), 32'd1);
    checkOutput("b2b.valid",     32'(rd_valid),  32'd1);
    checkOutput("b2b.metaA",     32'(rd_meta),   32'h71);
    checkOutput("b2b.totA",      32'(rd_tot),    32'd3);
    checkOutput("b2b.cellA",     32'(rd_cell),   32'd7);
    tick();
    readEvent("b2b.rdB", 8'h72, 8'd2, 3'd0);
    checkOutput("b2b.empty", 32'(empty), 32'd1);

    // Reset mid-pulse while sampling into cell 1
    metadata = 8'h55;
    TOT      = 1'b1;
    repeat (3) tick();
    checkOutput("midrst.wr_sel_pre", 32'(wr_sel), 32'h02);
    resetb_full = 1'b0;
    TOT         = 1'b0;
    tick();
    resetb_full = 1'b1;
    checkOutput("midrst.wr_sel",   32'(wr_sel),    32'h00);
    checkOutput("midrst.occ",      32'(occupancy), 32'd0);
    checkOutput("midrst.overflow", 32'(overflow),  32'd0);
    checkOutput("midrst.empty",    32'(empty),     32'd1);
    metadata = 8'h66;
    TOT      = 1'b1;
    tick();
    checkOutput("midrst.wr_selNext", 32'(wr_sel), 32'h01);
    repeat (3) tick();
    TOT = 1'b0;
    tick();
    readEvent("midrst.rd", 8'h66, 8'd4, 3'd0);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/amem_core_ctl.md
# amem_core_ctl

Digital controller for the APP analog memory core. It detects time-over-threshold (TOT) pulses from the channel front-end (the `app_1ch_behav` comparator path), allocates one of `NCELLS` analog storage cells per pulse, and drives that cell's one-hot sample select. For each event it records the 8-bit metadata and the TOT width in clock cycles, then hands stored events to the readout in FIFO order.

## Interface
Parameters:
- `NCELLS`, 8: number of analog memory cells; must be a power of two, 2..16.
- `CNT_W`, 8: width of the TOT width counter.
- `META_W`, 8: metadata width.

Ports:
- `clk`  in  1  single system clock, 50 MHz nominal.
- `resetb_full`  in  1  synchronous, active-low reset. One clock, `clk`; reset is synchronous and active-low.
- `TOT`  in  1  comparator time-over-threshold level, already synchronous to `clk`.
- `metadata`  in  `META_W`  event tag, sampled on the TOT rising edge.
- `rd_req`  in  1  readout request pulse.
- `rd_valid`  out  1  one-cycle strobe; the `rd_*` data outputs are valid while it is high.
- `rd_meta`  out  `META_W`  metadata of the event being read.
- `rd_tot`  out  `CNT_W`  TOT width of the event being read.
- `rd_cell`  out  `$clog2(NCELLS)`  cell index of the event being read.
- `wr_sel`  out  `NCELLS`  one-hot analog sample select; all zero when idle.
- `occupancy`  out  `$clog2(NCELLS)+1`  number of committed, unread events.
- `full`, `empty`  out  1  `occupancy==NCELLS` and `occupancy==0`.
- `overflow`  out  1  sticky flag: an event was dropped because no cell was free.

## Operation
- An edge detector registers `TOT` into `tot_q`. A rise is `TOT & ~tot_q`; a fall is `~TOT & tot_q`.
- The FSM has two states: IDLE and SAMPLE.
- **IDLE, rise, not full.** Capture `metadata` into `meta[wptr]`. Set `wr_sel = 1<<wptr`. Set `cnt = 1`. Go to SAMPLE.
- **IDLE, rise, full.** Drop the event: set `overflow = 1`, leave `wr_sel` at 0, stay in IDLE. The whole pulse is ignored.
- **SAMPLE, `TOT` high.** `cnt` increments and saturates at `2^CNT_W-1`.
- **SAMPLE, `TOT` low (fall).** Write `cnt` to `tot[wptr]`. Clear `wr_sel`. Increment `wptr` modulo `NCELLS`. Increment `occupancy`. Go to IDLE.
- **Readout.** When `rd_req=1`, `~empty` and `~rd_valid`, the next cycle drives `rd_valid=1` with `rd_meta=meta[rptr]`, `rd_tot=tot[rptr]` and `rd_cell=rptr`. On that cycle `rptr` increments modulo `NCELLS` and `occupancy` decrements.
- `rd_req` is ignored when the FIFO is empty or `rd_valid` is already high.
- If a commit and a read retire in the same cycle, `occupancy` is unchanged.
- A cell is never re-allocated before it has been read.
- `rd_*` data outputs hold their last value after `rd_valid` drops.

## Timing
- **Reset values.** Everything is zero: `wr_sel`, `rd_valid`, `rd_*`, `occupancy`, `overflow`, `wptr`, `rptr`, `cnt`, `tot_q`, and all storage. `empty=1`, `full=0`, state IDLE.
- **Reset during SAMPLE.** The in-flight event is discarded and `wr_sel` goes to 0 on the next edge.
- `wr_sel` asserts on the clock edge that samples the rise and deasserts on the edge that samples the fall.
- A TOT pulse high for k sampled edges gives `rd_tot = k`. The minimum is 1.
- Back-to-back pulses separated by a single low cycle are two separate events. The falling-edge commit and the new rise are one cycle apart.
- `occupancy`, `full` and `empty` update on the commit edge. Read latency is one cycle from `rd_req` to `rd_valid`.
- `rd_valid` is high for exactly one cycle per granted request.
- `overflow` clears only on reset.

## Structure
- Package `amem_pkg` holds:
  - default `NCELLS`/`CNT_W`/`META_W` constants;
  - the FSM state enum (`ST_IDLE`, `ST_SAMPLE`);
  - the one-hot decode function.
- Sub-module `amem_cell_bank` is the register-file storage of `meta`/`tot` per cell. It has one write port (index, enable, data) and one asynchronous read port (index).
- Control, pointers, counter and readout logic live in the top level.

## Test plan
- **Single event.** Reset, then `metadata=8'hA5` and TOT high for 5 cycles. Require `wr_sel=8'h01` during the pulse, `occupancy=1`, then after `rd_req`: `rd_valid` pulse with `rd_meta=A5`, `rd_tot=5`, `rd_cell=0`, `empty=1`.
- **Fill and overflow.** Send 8 pulses of widths 1..8 with `metadata=0..7`. Require `full=1`. A 9th pulse must give `wr_sel=0` and `overflow=1`. Reading 8 times must return widths 1..8 and tags 0..7 in order.
- **Saturation.** Hold TOT high for 300 cycles with `CNT_W=8`. Require `rd_tot=255`.
- **Back-to-back and simultaneous events.** Send two pulses separated by one low cycle, then issue `rd_req` on the commit cycle of the second. Require two separate events, `occupancy` steady across the simultaneous commit and read, and `wptr` wrapping from 7 to 0.
- **Reset mid-pulse.** Assert `resetb_full=0` for 1 cycle during SAMPLE. Require `wr_sel=0`, `occupancy=0`, `overflow=0`, and a next event allocated to cell 0.
- **Empty read.** Pulse `rd_req` with the FIFO empty. Require no `rd_valid` and `rptr` unchanged.
